// File: rtl/mcu_spi_pkg.sv
// Shared definitions for the MCU SPI slave front end: target IDs, FSM
// encoding, strobe bundle and the target decoder.
package mcu_spi_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  localparam logic [7:0] TGT_SYS = 8'h01;
  localparam logic [7:0] TGT_HID = 8'h02;
  localparam logic [7:0] TGT_OSD = 8'h03;
  localparam logic [7:0] TGT_SDC = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic sdc;
    logic osd;
    logic hid;
    logic sys;
  } strobe_t;

  // One-hot strobe for a target ID; unknown IDs select nothing.
  function automatic strobe_t decode_target(input logic [7:0] id);
    strobe_t s;
    s = '0;
    case (id)
      TGT_SYS: s.sys = 1'b1;
      TGT_HID: s.hid = 1'b1;
      TGT_OSD: s.osd = 1'b1;
      TGT_SDC: s.sdc = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mcu_spi_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input; reset value is
// selectable so idle-high lines come out of reset inactive.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mcu_spi.sv
// SPI slave (mode 0) bridging the MCU link to the byte/strobe bus of the
// SYS, HID, OSD and SDC blocks, with per-target readback on MISO.
module mcu_spi
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_start,
  output logic [7:0] mcu_data,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_sdc_din
);

  logic ss_s, sclk_s, din_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d_i(spi_io_ss), .q_o(ss_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .reset(reset), .d_i(spi_io_clk), .q_o(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .reset(reset), .d_i(spi_io_din), .q_o(din_s)
  );

  logic                   ss_q, sclk_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   armed_q;
  state_t                 state_q;
  logic [7:0]             rx_q, tx_q, byte_q, target_q, data_q;
  logic [2:0]             bitcnt_q;
  logic                   done_q, skip_q, start_q;
  strobe_t                stb_q;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  // SS edges only count once a genuine high level has been seen after reset,
  // so a frame interrupted by reset is ignored until SS toggles again.
  assign ss_fall   = armed_q &  ss_q & ~ss_s;
  assign ss_rise   = armed_q & ~ss_q &  ss_s;
  assign sclk_rise = ~sclk_q &  sclk_s;
  assign sclk_fall =  sclk_q & ~sclk_s;

  logic [7:0] cur_tgt;
  strobe_t    cur_stb;
  logic [7:0] rb;

  assign cur_tgt = (state_q == ST_CMD) ? byte_q : target_q;
  assign cur_stb = decode_target(cur_tgt);

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    rb = 8'h00;
    case (cur_tgt)
      TGT_SYS: rb = mcu_sys_din;
      TGT_HID: rb = mcu_hid_din;
      TGT_SDC: rb = mcu_sdc_din;
      default: rb = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_q     <= 1'b1;
      sclk_q   <= 1'b0;
      vld_q    <= '0;
      armed_q  <= 1'b0;
      state_q  <= ST_IDLE;
      rx_q     <= 8'h00;
      tx_q     <= 8'h00;
      byte_q   <= 8'h00;
      target_q <= 8'h00;
      data_q   <= 8'h00;
      bitcnt_q <= 3'd0;
      done_q   <= 1'b0;
      skip_q   <= 1'b0;
      start_q  <= 1'b0;
      stb_q    <= '0;
    end else begin
      ss_q    <= ss_s;
      sclk_q  <= sclk_s;
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      if (vld_q[SYNC_STAGES-1] && ss_s) armed_q <= 1'b1;
      start_q <= 1'b0;
      stb_q   <= '0;
      done_q  <= 1'b0;

      // An SS edge in the same cycle as an SCLK edge takes priority.
      if (ss_rise) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= 3'd0;
        rx_q     <= 8'h00;
      end else if (ss_fall) begin
        state_q  <= ST_CMD;
        bitcnt_q <= 3'd0;
        rx_q     <= 8'h00;
        tx_q     <= 8'h00;
        skip_q   <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sclk_rise) begin
          rx_q     <= {rx_q[6:0], din_s};
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            byte_q <= {rx_q[6:0], din_s};
            done_q <= 1'b1;
          end
        end else if (sclk_fall) begin
          if (skip_q) skip_q <= 1'b0;
          else        tx_q   <= {tx_q[6:0], 1'b0};
        end
      end

      // Byte completion is registered one cycle after the capturing edge.
      if (done_q) begin
        data_q <= byte_q;
        stb_q  <= cur_stb;
        tx_q   <= rb;
        skip_q <= 1'b1;
        if (state_q == ST_CMD) begin
          target_q <= byte_q;
          start_q  <= 1'b1;
          if (!ss_rise) state_q <= ST_DATA;
        end
      end
    end
  end

  assign spi_io_dout    = (state_q != ST_IDLE) && tx_q[7];
  assign mcu_start      = start_q;
  assign mcu_data       = data_q;
  assign mcu_sys_strobe = stb_q.sys;
  assign mcu_hid_strobe = stb_q.hid;
  assign mcu_osd_strobe = stb_q.osd;
  assign mcu_sdc_strobe = stb_q.sdc;

endmodule
